// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared mode constants and segment sizing for the GF/integer pipelined adder
package gf_pkg;

    localparam logic GF_MODE_INT = 1'b0;
    localparam logic GF_MODE_GF  = 1'b1;

    function automatic int unsigned seg_width(input int unsigned data_width,
                                              input int unsigned num_stages);
        return data_width / num_stages;
    endfunction

endpackage

// File: rtl/gf_adder_slice.sv
// rtl/gf_adder_slice.sv - one SEG-bit ripple segment; carries are suppressed in GF(2) mode
module gf_adder_slice
    import gf_pkg::*;
#(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    input  logic           gf_option,
    output logic [SEG-1:0] sum,
    output logic           co
);

    logic carry;

    always_comb begin
        carry = ci & (gf_option == GF_MODE_INT);
        sum   = '0;
        for (int i = 0; i < int'(SEG); i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (gf_option == GF_MODE_GF) ? 1'b0
                   : ((a[i] & b[i]) | (carry & (a[i] ^ b[i])));
        end
        co = carry;
    end

endmodule

// File: rtl/gf_pipe_adder.sv
// rtl/gf_pipe_adder.sv - segmented pipelined adder with per-transaction GF(2)/integer mode
module gf_pipe_adder
    import gf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  gf_option,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  ci,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  co
);

    localparam int unsigned SEG = seg_width(DATA_WIDTH, NUM_STAGES);

    if ((DATA_WIDTH % NUM_STAGES) != 0) begin : g_bad_width
        $error("gf_pipe_adder: DATA_WIDTH must be divisible by NUM_STAGES");
    end

    // Stage k registers hold the operands still to be added (skew) and the
    // low sum segments already finished (deskew), so a whole word moves as one.
    logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] a_q, b_q, s_q;
    logic [NUM_STAGES-1:0]                 v_q, gf_q, c_q;

    logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] stg_a, stg_b, stg_s;
    logic [NUM_STAGES-1:0]                 stg_v, stg_gf, stg_c;
    logic [NUM_STAGES-1:0][SEG-1:0]        seg_sum;
    logic [NUM_STAGES-1:0]                 seg_co;

    logic adv;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[NUM_STAGES-1];
    assign sum       = s_q[NUM_STAGES-1];
    assign co        = c_q[NUM_STAGES-1];

    always_comb begin
        stg_v  = '0;
        stg_gf = '0;
        stg_c  = '0;
        stg_a  = '0;
        stg_b  = '0;
        stg_s  = '0;
        stg_v[0]  = in_valid;
        stg_gf[0] = gf_option;
        stg_c[0]  = ci & (gf_option == GF_MODE_INT);
        stg_a[0]  = a;
        stg_b[0]  = b;
        for (int k = 1; k < int'(NUM_STAGES); k++) begin
            stg_v[k]  = v_q[k-1];
            stg_gf[k] = gf_q[k-1];
            stg_c[k]  = c_q[k-1];
            stg_a[k]  = a_q[k-1];
            stg_b[k]  = b_q[k-1];
            stg_s[k]  = s_q[k-1];
        end
    end

    for (genvar k = 0; k < int'(NUM_STAGES); k++) begin : g_slice
        gf_adder_slice #(
            .SEG(SEG)
        ) u_slice (
            .a        (stg_a[k][k*SEG +: SEG]),
            .b        (stg_b[k][k*SEG +: SEG]),
            .ci       (stg_c[k]),
            .gf_option(stg_gf[k]),
            .sum      (seg_sum[k]),
            .co       (seg_co[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            gf_q <= '0;
            c_q  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            s_q  <= '0;
        end else if (adv) begin
            for (int k = 0; k < int'(NUM_STAGES); k++) begin
                v_q[k]  <= stg_v[k];
                gf_q[k] <= stg_gf[k];
                c_q[k]  <= seg_co[k];
                a_q[k]  <= stg_a[k];
                b_q[k]  <= stg_b[k];
                s_q[k]  <= stg_s[k];
                s_q[k][k*SEG +: SEG] <= seg_sum[k];
            end
        end
    end

endmodule

// File: tb/tb_gf_pipe_adder.sv
// tb/tb_gf_pipe_adder.sv - scoreboard bench for gf_pipe_adder with directed and random traffic
module tb_gf_pipe_adder;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        gf_option;
    logic [31:0] a, b;
    logic        ci;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        co;

    gf_pipe_adder #(.DATA_WIDTH(32), .NUM_STAGES(NS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .gf_option(gf_option), .a(a), .b(b), .ci(ci),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .co(co)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] res;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    function automatic logic [32:0] model(input bit g, input logic [31:0] x,
                                          input logic [31:0] y, input bit c);
        if (g) return {1'b0, x ^ y};
        return {1'b0, x} + {1'b0, y} + 33'(c);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops on every consumed result and checks hold stability under backpressure.
    bit          hold_prev = 0;
    logic [32:0] prev_out;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            hold_prev = 0;
        end else begin
            if (hold_prev)
                chk("hold_stable", {30'd0, out_valid, co, sum}, {30'd0, 1'b1, prev_out});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {31'd0, co, sum}, 64'h1_0000_0000_0000);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", {31'd0, co, sum}, {31'd0, e.res});
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(NS));
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_out  = {co, sum};
        end
    end

    task automatic drive_one(input bit v, input bit g, input logic [31:0] aa,
                             input logic [31:0] bb, input bit c, input bit lat,
                             output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        gf_option = g;
        a         = aa;
        b         = bb;
        ci        = c;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e.res = model(g, aa, bb, c);
            e.cyc = cyc;
            e.lat = lat;
            sb.push_back(e);
            acc_cnt++;
        end
    endtask

    task automatic send(input bit g, input logic [31:0] aa, input logic [31:0] bb,
                        input bit c, input bit lat);
        bit acc = 0;
        int tries = 0;
        while (!acc && tries < 200) begin
            drive_one(1'b1, g, aa, bb, c, lat, acc);
            tries++;
        end
        if (!acc) chk("send_timeout", 64'(tries), 64'd0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int budget;
        bit acc;
        rst_n = 1'b0;
        in_valid = 1'b0;
        gf_option = 1'b0;
        a = '0;
        b = '0;
        ci = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_co", 64'(co), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        rdy_mode = 1;
        send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        drain(20);
        send(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
        drain(20);

        send(1'b0, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        send(1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b1);
        send(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        drain(20);

        rdy_mode = 0;
        acc_cnt = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(1'(i % 2), $urandom, $urandom, 1'(i / 3), 1'b0);
            end
            begin
                repeat (10) @(negedge clk);
                #3;
                chk("bp_accepts", 64'(acc_cnt), 64'd4);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                rdy_mode = 1;
            end
        join
        drain(40);
        chk("bp_total_accepts", 64'(acc_cnt), 64'd6);

        send(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);
        send(1'b1, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b1, 1'b1);
        send(1'b0, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_co", 64'(co), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b1, 1'b1);
        drain(20);

        rdy_mode = 2;
        n = 0;
        budget = 0;
        while (n < 10000 && budget < 60000) begin
            drive_one(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
                      $urandom, 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) n++;
            budget++;
        end
        chk("soak_transfers", 64'(n), 64'd10000);
        rdy_mode = 1;
        drain(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
